// File: rtl/i2c_target_regs_pkg.sv
// Shared types and sizing for the I2C register target.
package i2c_target_regs_pkg;
   localparam int unsigned NUM_REGS = 16;
   localparam int unsigned PTR_W    = 4;

   typedef logic [PTR_W-1:0] ptr_t;

   typedef enum logic [3:0] {
      ST_IDLE       = 4'd0,
      ST_ADDR       = 4'd1,
      ST_ADDR_ACK   = 4'd2,
      ST_PTR        = 4'd3,
      ST_PTR_ACK    = 4'd4,
      ST_WDATA      = 4'd5,
      ST_WDATA_ACK  = 4'd6,
      ST_RDATA      = 4'd7,
      ST_RDATA_MACK = 4'd8,
      ST_IGNORE     = 4'd9
   } state_t;
endpackage

// File: rtl/i2c_target_regs_if.sv
// Pad and local-access signals of the I2C register target.
interface i2c_target_regs_if;
   import i2c_target_regs_pkg::*;

   logic       scl_i;
   logic       sda_i;
   logic       sda_oe_o;
   ptr_t       loc_addr_i;
   logic [7:0] loc_data_o;
   logic       wr_strobe_o;
   ptr_t       wr_addr_o;
   logic [7:0] wr_data_o;
   logic       busy_o;

   modport slave (
      input  scl_i, sda_i, loc_addr_i,
      output sda_oe_o, loc_data_o, wr_strobe_o, wr_addr_o, wr_data_o, busy_o
   );

   modport master (
      output scl_i, sda_i, loc_addr_i,
      input  sda_oe_o, loc_data_o, wr_strobe_o, wr_addr_o, wr_data_o, busy_o
   );
endinterface

// File: rtl/i2c_target_regs_sync_edge.sv
// Two-flop synchronizer with rise/fall detection on the synchronized level.
module i2c_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic i_async,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);
   logic r_meta;
   logic r_sync;
   logic r_prev;

   // Reset to the idle-bus level so no false edges fire after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
         r_prev <= 1'b1;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_level = r_sync;
   assign o_rise  = r_sync & ~r_prev;
   assign o_fall  = ~r_sync & r_prev;
endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with a 16 x 8-bit register file, auto-incrementing pointer,
// local read port and per-byte write strobe.
module i2c_target_regs
   import i2c_target_regs_pkg::*;
#(
   parameter logic [6:0] TARGET_ADDR = 7'h50
) (
   input logic               clk,
   input logic               rst,
   i2c_target_regs_if.slave  bus
);
   logic w_scl, w_scl_rise, w_scl_fall;
   logic w_sda, w_sda_rise, w_sda_fall;
   logic w_start, w_stop;
   logic [7:0] w_byte;

   i2c_sync_edge u_scl (.clk(clk), .rst(rst), .i_async(bus.scl_i),
                        .o_level(w_scl), .o_rise(w_scl_rise), .o_fall(w_scl_fall));
   i2c_sync_edge u_sda (.clk(clk), .rst(rst), .i_async(bus.sda_i),
                        .o_level(w_sda), .o_rise(w_sda_rise), .o_fall(w_sda_fall));

   assign w_start = w_sda_fall & w_scl;
   assign w_stop  = w_sda_rise & w_scl;

   state_t     r_state, w_state_nxt;
   logic [2:0] r_bitcnt, w_bitcnt_nxt;
   logic [7:0] r_shift, w_shift_nxt;
   ptr_t       r_ptr, w_ptr_nxt;
   logic       r_rw, w_rw_nxt;
   logic       r_ackph, w_ackph_nxt;
   logic       r_sda_oe, w_sda_oe_nxt;
   logic       r_busy, w_busy_nxt;
   logic       w_wr_en;
   logic       r_wr_strobe;
   ptr_t       r_wr_addr;
   logic [7:0] r_wr_data;
   logic [7:0] r_regs [NUM_REGS];

   assign w_byte = {r_shift[6:0], w_sda};

   // r_ackph: in *_ACK states, set once SDA is pulled; in RDATA, marks that
   // the first bit of the byte is still pending the next SCL fall.
   always_comb begin
      w_state_nxt  = r_state;
      w_bitcnt_nxt = r_bitcnt;
      w_shift_nxt  = r_shift;
      w_ptr_nxt    = r_ptr;
      w_rw_nxt     = r_rw;
      w_ackph_nxt  = r_ackph;
      w_sda_oe_nxt = r_sda_oe;
      w_busy_nxt   = r_busy;
      w_wr_en      = 1'b0;
      if (w_stop) begin
         w_state_nxt  = ST_IDLE;
         w_sda_oe_nxt = 1'b0;
         w_busy_nxt   = 1'b0;
         w_ackph_nxt  = 1'b0;
      end else if (w_start) begin
         w_state_nxt  = ST_ADDR;
         w_bitcnt_nxt = '0;
         w_sda_oe_nxt = 1'b0;
         w_ackph_nxt  = 1'b0;
      end else begin
         case (r_state)
            ST_ADDR, ST_PTR, ST_WDATA: begin
               if (w_scl_rise) begin
                  w_shift_nxt  = w_byte;
                  w_bitcnt_nxt = r_bitcnt + 3'd1;
                  if (r_bitcnt == 3'd7) begin
                     if (r_state == ST_ADDR) begin
                        if (w_byte[7:1] == TARGET_ADDR) begin
                           w_state_nxt = ST_ADDR_ACK;
                           w_rw_nxt    = w_byte[0];
                           w_busy_nxt  = 1'b1;
                        end else begin
                           w_state_nxt = ST_IGNORE;
                        end
                     end else if (r_state == ST_PTR) begin
                        w_ptr_nxt   = w_byte[PTR_W-1:0];
                        w_state_nxt = ST_PTR_ACK;
                     end else begin
                        w_wr_en     = 1'b1;
                        w_ptr_nxt   = r_ptr + 4'd1;
                        w_state_nxt = ST_WDATA_ACK;
                     end
                  end
               end
            end
            ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
               if (w_scl_fall) begin
                  if (!r_ackph) begin
                     w_sda_oe_nxt = 1'b1;
                     w_ackph_nxt  = 1'b1;
                  end else begin
                     w_sda_oe_nxt = 1'b0;
                     w_ackph_nxt  = 1'b0;
                     w_bitcnt_nxt = '0;
                     if (r_state == ST_ADDR_ACK && r_rw) begin
                        w_state_nxt  = ST_RDATA;
                        w_shift_nxt  = r_regs[r_ptr];
                        w_sda_oe_nxt = ~r_regs[r_ptr][7];
                     end else if (r_state == ST_ADDR_ACK) begin
                        w_state_nxt = ST_PTR;
                     end else begin
                        w_state_nxt = ST_WDATA;
                     end
                  end
               end
            end
            ST_RDATA: begin
               if (w_scl_fall) begin
                  if (r_ackph) begin
                     w_sda_oe_nxt = ~r_shift[7];
                     w_ackph_nxt  = 1'b0;
                     w_bitcnt_nxt = '0;
                  end else if (r_bitcnt == 3'd7) begin
                     w_sda_oe_nxt = 1'b0;
                     w_ptr_nxt    = r_ptr + 4'd1;
                     w_state_nxt  = ST_RDATA_MACK;
                  end else begin
                     w_shift_nxt  = {r_shift[6:0], 1'b0};
                     w_sda_oe_nxt = ~r_shift[6];
                     w_bitcnt_nxt = r_bitcnt + 3'd1;
                  end
               end
            end
            ST_RDATA_MACK: begin
               if (w_scl_rise) begin
                  if (w_sda) begin
                     w_state_nxt = ST_IGNORE;
                  end else begin
                     w_state_nxt  = ST_RDATA;
                     w_shift_nxt  = r_regs[r_ptr];
                     w_ackph_nxt  = 1'b1;
                     w_bitcnt_nxt = '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_bitcnt    <= '0;
         r_shift     <= '0;
         r_ptr       <= '0;
         r_rw        <= 1'b0;
         r_ackph     <= 1'b0;
         r_sda_oe    <= 1'b0;
         r_busy      <= 1'b0;
         r_wr_strobe <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_bitcnt    <= w_bitcnt_nxt;
         r_shift     <= w_shift_nxt;
         r_ptr       <= w_ptr_nxt;
         r_rw        <= w_rw_nxt;
         r_ackph     <= w_ackph_nxt;
         r_sda_oe    <= w_sda_oe_nxt;
         r_busy      <= w_busy_nxt;
         r_wr_strobe <= w_wr_en;
         if (w_wr_en) begin
            r_wr_addr      <= r_ptr;
            r_wr_data      <= w_byte;
            r_regs[r_ptr]  <= w_byte;
         end
      end
   end

   assign bus.sda_oe_o    = r_sda_oe;
   assign bus.busy_o      = r_busy;
   assign bus.wr_strobe_o = r_wr_strobe;
   assign bus.wr_addr_o   = r_wr_addr;
   assign bus.wr_data_o   = r_wr_data;
   assign bus.loc_data_o  = r_regs[bus.loc_addr_i];
endmodule

// File: tb/tb_i2c_target_regs.sv
// Bit-banged I2C master with a transaction-level register/pointer model.
module tb_i2c_target_regs;
   import i2c_target_regs_pkg::*;

   localparam logic [6:0] ADDR = 7'h50;

   logic       clk = 1'b0;
   logic       rst;
   logic       r_m_scl;
   logic       r_m_sda;
   logic [3:0] r_loc_addr;

   always #5 clk = ~clk;

   i2c_target_regs_if bus ();
   assign bus.scl_i      = r_m_scl;
   assign bus.sda_i      = r_m_sda & ~bus.sda_oe_o;
   assign bus.loc_addr_i = r_loc_addr;

   i2c_target_regs #(.TARGET_ADDR(ADDR)) dut (.clk(clk), .rst(rst), .bus(bus));

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   logic [7:0]  m_regs [16];
   logic [3:0]  m_ptr;
   logic [11:0] q_exp [$];
   int          n_strb_chk = 0;

   // Monitor-owned observations
   logic [11:0] q_obs [$];
   int unsigned oe_seen = 0, busy_seen = 0, oe_glitch = 0;
   logic        r_prev_oe = 1'b0;

   always @(negedge clk) begin
      if (bus.sda_oe_o !== r_prev_oe && r_m_scl) oe_glitch <= oe_glitch + 1;
      r_prev_oe <= bus.sda_oe_o;
      if (bus.sda_oe_o) oe_seen <= oe_seen + 1;
      if (bus.busy_o) busy_seen <= busy_seen + 1;
      if (bus.wr_strobe_o) q_obs.push_back({bus.wr_addr_o, bus.wr_data_o});
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_bit(input logic b, output logic s);
      tick(3); r_m_sda = b;
      tick(5); r_m_scl = 1'b1;
      tick(4); s = bus.sda_i;
      tick(4); r_m_scl = 1'b0;
   endtask

   task automatic bus_start();
      tick(8); r_m_sda = 1'b1;
      tick(4); r_m_scl = 1'b1;
      tick(8); r_m_sda = 1'b0;
      tick(8); r_m_scl = 1'b0;
   endtask

   task automatic bus_stop();
      tick(8); r_m_sda = 1'b0;
      tick(4); r_m_scl = 1'b1;
      tick(8); r_m_sda = 1'b1;
      tick(8);
   endtask

   task automatic wr_byte(input logic [7:0] d, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
      bus_bit(1'b1, s);
      ack = ~s;
   endtask

   task automatic rd_byte(input logic last, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bus_bit(1'b1, s);
         d[i] = s;
      end
      bus_bit(last, s);
   endtask

   task automatic check_strobes();
      check_eq("strobe_count", q_obs.size(), q_exp.size());
      for (int i = n_strb_chk; i < q_exp.size() && i < q_obs.size(); i++)
         check_eq("strobe", q_obs[i], q_exp[i]);
      n_strb_chk = q_exp.size();
   endtask

   task automatic check_all_regs();
      for (int i = 0; i < 16; i++) begin
         r_loc_addr = 4'(i);
         #1;
         check_eq("loc_data", bus.loc_data_o, m_regs[i]);
      end
   endtask

   task automatic txn_write(input logic [7:0] pbyte, input logic [7:0] data [$]);
      logic ack;
      bus_start();
      wr_byte({ADDR, 1'b0}, ack);
      check_eq("wr_addr_ack", ack, 1);
      check_eq("busy_hi", bus.busy_o, 1);
      wr_byte(pbyte, ack);
      check_eq("ptr_ack", ack, 1);
      m_ptr = pbyte[3:0];
      foreach (data[k]) begin
         wr_byte(data[k], ack);
         check_eq("data_ack", ack, 1);
         q_exp.push_back({m_ptr, data[k]});
         m_regs[m_ptr] = data[k];
         m_ptr = m_ptr + 4'd1;
      end
      bus_stop();
      check_eq("busy_lo", bus.busy_o, 0);
      check_strobes();
   endtask

   task automatic txn_read(input logic set_ptr, input logic [7:0] pbyte, input int n);
      logic ack;
      logic [7:0] d;
      bus_start();
      if (set_ptr) begin
         wr_byte({ADDR, 1'b0}, ack);
         check_eq("rs_addr_ack", ack, 1);
         wr_byte(pbyte, ack);
         check_eq("rs_ptr_ack", ack, 1);
         m_ptr = pbyte[3:0];
         bus_start();
      end
      wr_byte({ADDR, 1'b1}, ack);
      check_eq("rd_addr_ack", ack, 1);
      for (int k = 0; k < n; k++) begin
         rd_byte(k == n - 1, d);
         check_eq("rd_data", d, m_regs[m_ptr]);
         m_ptr = m_ptr + 4'd1;
      end
      tick(8);
      check_eq("rd_release", bus.sda_oe_o, 0);
      bus_stop();
      check_eq("ptr", dut.r_ptr, m_ptr);
   endtask

   initial begin
      logic [7:0] dq [$];
      logic ack, s;
      int unsigned oe0, busy0, sel, n;

      rst = 1'b1; r_m_scl = 1'b1; r_m_sda = 1'b1; r_loc_addr = '0;
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      m_ptr = '0;
      tick(4);
      check_eq("rst_oe", bus.sda_oe_o, 0);
      check_eq("rst_strobe", bus.wr_strobe_o, 0);
      check_eq("rst_wr_addr", bus.wr_addr_o, 0);
      check_eq("rst_wr_data", bus.wr_data_o, 0);
      check_eq("rst_busy", bus.busy_o, 0);
      rst = 1'b0;
      tick(4);
      check_all_regs();

      // Write burst, then repeated-start read with ACK then NACK
      dq = '{8'hA5, 8'h5A};
      txn_write(8'h03, dq);
      check_all_regs();
      txn_read(1'b1, 8'h03, 2);
      check_eq("ptr_after_read", dut.r_ptr, 5);

      // Address mismatch
      oe0 = oe_seen; busy0 = busy_seen;
      bus_start();
      wr_byte({7'h51, 1'b0}, ack);
      check_eq("mismatch_nack", ack, 0);
      wr_byte(8'h03, ack);
      wr_byte(8'h77, ack);
      bus_stop();
      check_eq("mismatch_oe", oe_seen - oe0, 0);
      check_eq("mismatch_busy", busy_seen - busy0, 0);
      check_strobes();
      check_all_regs();

      // Pointer wrap
      dq = '{8'h11, 8'h22};
      txn_write(8'h0F, dq);
      r_loc_addr = 4'hF; #1;
      check_eq("wrap_r15", bus.loc_data_o, 8'h11);
      r_loc_addr = 4'h0; #1;
      check_eq("wrap_r0", bus.loc_data_o, 8'h22);

      // Abort after 4 data bits
      bus_start();
      wr_byte({ADDR, 1'b0}, ack);
      check_eq("abort_addr_ack", ack, 1);
      wr_byte(8'h06, ack);
      check_eq("abort_ptr_ack", ack, 1);
      m_ptr = 4'h6;
      for (int i = 0; i < 4; i++) bus_bit(i < 2, s);
      bus_stop();
      check_eq("abort_state", 32'(dut.r_state), 32'(ST_IDLE));
      check_strobes();
      check_all_regs();
      dq = '{8'h9E};
      txn_write(8'h0A, dq);
      check_all_regs();

      // Reset while the target drives a 0 bit
      dq = '{8'h3C};
      txn_write(8'h09, dq);
      bus_start();
      wr_byte({ADDR, 1'b0}, ack);
      wr_byte(8'h09, ack);
      bus_start();
      wr_byte({ADDR, 1'b1}, ack);
      check_eq("rr_addr_ack", ack, 1);
      tick(7);
      check_eq("rr_drive0", bus.sda_oe_o, 1);
      rst = 1'b1;
      tick(1);
      check_eq("rr_release", bus.sda_oe_o, 0);
      rst = 1'b0;
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      m_ptr = '0;
      r_m_sda = 1'b1;
      tick(4); r_m_scl = 1'b1;
      tick(8);
      check_eq("rr_ptr", dut.r_ptr, 0);
      check_eq("rr_state", 32'(dut.r_state), 32'(ST_IDLE));
      check_all_regs();

      // Randomized transactions
      for (int it = 0; it < 24; it++) begin
         sel = $urandom_range(0, 2);
         if (sel == 0) begin
            dq.delete();
            n = $urandom_range(0, 4);
            for (int k = 0; k < int'(n); k++) dq.push_back(8'($urandom));
            txn_write(8'($urandom), dq);
         end else if (sel == 1) begin
            txn_read(1'b1, 8'($urandom), int'($urandom_range(1, 4)));
         end else begin
            txn_read(1'b0, 8'h00, int'($urandom_range(1, 3)));
         end
      end
      check_all_regs();
      check_eq("oe_hold", oe_glitch, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
